multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multicycle sequencer for the 4-bit-opcode MIPS datapath: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB
//  over several cycles, sharing one ALU and one memory port. Sits between instruction register and datapath muxes.
//  Waits on a memory ready handshake, counts retired instructions, stops on HALT or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting on memReady before error halt (1..2^TO_W-1)
//  TO_W         8    width of the timeout counter
//  CNT_W        16   width of the retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      synchronous reset, active low
//  opCode       in   4      IR[15:12], valid from DECODE onward
//  zero         in   1      ALU zero flag
//  memReady     in   1      memory completes the access this cycle
//  pcWrite      out  1      load PC (already gated by zero for BEQ)
//  pcSrc        out  2      00 ALU result, 01 ALUOut reg, 10 jump target
//  iorD         out  1      memory address: 0 PC, 1 ALUOut
//  irWrite      out  1      load IR
//  memRead      out  1      memory read request
//  memWrite     out  1      memory write request
//  regDst       out  1      write reg: 1 rd, 0 rt
//  memToReg     out  1      write data: 1 MDR, 0 ALUOut
//  regWrite     out  1      register file write enable
//  aluSrcA      out  1      0 PC, 1 regA
//  aluSrcB      out  2      00 regB, 01 const 1, 10 sign-ext imm, 11 branch offset
//  aluOp        out  4      0000 R(funct), 1000 add, 1001 sub, 1010 and, 1011 or, 1111 slt
//  halted       out  1      core stopped (HALT or error), sticky
//  memErr       out  1      timeout occurred, sticky
//  illegalOp    out  1      undefined opcode decoded, sticky
//  instrCount   out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=FETCH, counters=0, sticky flags=0. Outputs are decoded from state; every strobe is 0
//    while rst_n=0. Reset mid-access abandons it; no write strobe on the cycle after reset deasserts unless state demands it.
//  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=1000, pcSrc=00; irWrite=pcWrite=memReady. Stays until memReady.
//  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=1000 (branch target into ALUOut). Next state by opCode:
//    0000->EXEC_R; 0001/0100->MEM_ADDR; 0010->BRANCH; 0011/0101/0110/0111->EXEC_I; 1000->JUMP; 1111->HALT;
//    any other->FETCH, illegalOp=1, counted as retired (NOP).
//  - EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=0000 -> WB_R (regDst=1, regWrite=1, memToReg=0) -> FETCH.
//  - EXEC_I: aluSrcA=1, aluSrcB=10, aluOp = ORi 1011 / ANDi 1010 / ADDi 1000 / SLTi 1111 -> WB_I (regDst=0, regWrite=1) -> FETCH.
//  - MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=1000 -> MEM_RD (LW) or MEM_WR (SW).
//  - MEM_RD: memRead=1, iorD=1; on memReady -> WB_MEM (regDst=0, memToReg=1, regWrite=1) -> FETCH.
//  - MEM_WR: memWrite=1, iorD=1; on memReady -> FETCH. memWrite held continuously until accepted.
//  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=1001, pcSrc=01, pcWrite=zero -> FETCH.
//  - JUMP: pcSrc=10, pcWrite=1 -> FETCH.
//  - HALT: all strobes 0, halted=1; absorbing until reset.
//  - Latency at zero wait (memReady=1): BEQ/J 3 cycles, R/I/SW 4, LW 5. Each wait cycle adds one.
//  - Timeout: counter clears on entering FETCH/MEM_RD/MEM_WR, increments per waiting cycle; reaching MEM_TIMEOUT
//    without memReady -> HALT with memErr=1. memReady on the MEM_TIMEOUT-th cycle wins (no error).
//  - instrCount increments on the final cycle of each instruction (transition to FETCH), saturates at all-ones;
//    HALT itself is not counted.
// STRUCTURE
//  - mips_ctrl_pkg: opcode constants, aluOp encodings, aluSrcB/pcSrc encodings, state enum (4-bit).
//  - Single module: state register, timeout counter, instruction counter, combinational output decode. No sub-module.
// TESTING
//  - Reset: rst_n=0 for 2 cycles mid MEM_WR -> memWrite=0 during reset, state=FETCH, instrCount=0 after release.
//  - ADDi (0110), memReady=1: FETCH,DECODE,EXEC_I(aluOp=1000,aluSrcB=10),WB_I(regWrite=1) -> 4 cycles, instrCount=1.
//  - LW with 3 wait cycles in MEM_RD: memRead,iorD=1 held 4 cycles, then WB_MEM memToReg=1 -> total 8 cycles.
//  - BEQ zero=1 -> pcWrite=1,pcSrc=01 in BRANCH; zero=0 -> pcWrite=0; both return to FETCH after 3 cycles.
//  - memReady never asserted in FETCH, MEM_TIMEOUT=4 -> halted=1, memErr=1 after 4 cycles; strobes stay 0 thereafter.
//  - opCode=1010 -> illegalOp=1, back to FETCH, instrCount+1; then 1111 -> halted=1, instrCount unchanged.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALU controls,
// mux selects and the sequencer state enum.
package mips_ctrl_pkg;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OpRType = 4'b0000;
  localparam logic [3:0] OpLw    = 4'b0001;
  localparam logic [3:0] OpBeq   = 4'b0010;
  localparam logic [3:0] OpOri   = 4'b0011;
  localparam logic [3:0] OpSw    = 4'b0100;
  localparam logic [3:0] OpAndi  = 4'b0101;
  localparam logic [3:0] OpAddi  = 4'b0110;
  localparam logic [3:0] OpSlti  = 4'b0111;
  localparam logic [3:0] OpJ     = 4'b1000;
  localparam logic [3:0] OpHalt  = 4'b1111;

  // ALU operation controls
  localparam logic [3:0] AluFunct = 4'b0000;
  localparam logic [3:0] AluAdd   = 4'b1000;
  localparam logic [3:0] AluSub   = 4'b1001;
  localparam logic [3:0] AluAnd   = 4'b1010;
  localparam logic [3:0] AluOr    = 4'b1011;
  localparam logic [3:0] AluSlt   = 4'b1111;

  // ALU B operand select
  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBOne   = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBBrOff = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StMemAddr,
    StMemRd,
    StMemWr,
    StWbMem,
    StBranch,
    StJump,
    StHalt
  } state_e;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the 4-bit-opcode MIPS datapath. Steps each instruction through
// fetch/decode/execute/memory/writeback, waits on memReady with a timeout, counts retired
// instructions and stops on HALT or a memory timeout.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opCode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             iorD,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [3:0]       aluOp,
  output logic             halted,
  output logic             memErr,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  // Last waiting cycle allowed before the access is declared lost
  localparam logic [TO_W-1:0] ToLast = TO_W'(MEM_TIMEOUT - 1);

  state_e           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             r_mem_err;
  logic             r_illegal;

  state_e w_next;
  logic   w_mem_state;
  logic   w_wait;
  logic   w_timeout;
  logic   w_retire;
  logic   w_illegal_dec;
  logic   w_enter_mem;

  assign w_mem_state   = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_wait        = w_mem_state && !memReady;
  assign w_timeout     = w_wait && (r_to_cnt == ToLast);
  assign w_retire      = (r_state != StFetch) && (w_next == StFetch);
  assign w_illegal_dec = (r_state == StDecode) && (w_next == StFetch);
  assign w_enter_mem   = (w_next != r_state) &&
                         ((w_next == StFetch) || (w_next == StMemRd) || (w_next == StMemWr));

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      StFetch:   w_next = memReady ? StDecode : (w_timeout ? StHalt : StFetch);
      StDecode: begin
        case (opCode)
          OpRType:                         w_next = StExecR;
          OpLw, OpSw:                      w_next = StMemAddr;
          OpBeq:                           w_next = StBranch;
          OpOri, OpAndi, OpAddi, OpSlti:   w_next = StExecI;
          OpJ:                             w_next = StJump;
          OpHalt:                          w_next = StHalt;
          default:                         w_next = StFetch; // undefined opcode retires as NOP
        endcase
      end
      StExecR:   w_next = StWbR;
      StExecI:   w_next = StWbI;
      StMemAddr: w_next = (opCode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   w_next = memReady ? StWbMem : (w_timeout ? StHalt : StMemRd);
      StMemWr:   w_next = memReady ? StFetch : (w_timeout ? StHalt : StMemWr);
      StWbR, StWbI, StWbMem, StBranch, StJump: w_next = StFetch;
      StHalt:    w_next = StHalt;
      default:   w_next = StFetch;
    endcase
  end

  // State register, timeout counter, retire counter and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StFetch;
      r_to_cnt    <= '0;
      r_instr_cnt <= '0;
      r_mem_err   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_mem) begin
        r_to_cnt <= '0;
      end else if (w_wait) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_retire && (r_instr_cnt != {CNT_W{1'b1}})) begin
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
      if (w_illegal_dec) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Datapath control decode; all strobes forced low while reset is asserted
  always_comb begin
    pcWrite  = 1'b0;
    pcSrc    = PcSrcAlu;
    iorD     = 1'b0;
    irWrite  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = SrcBRegB;
    aluOp    = AluFunct;
    if (rst_n) begin
      case (r_state)
        StFetch: begin
          memRead = 1'b1;
          aluSrcB = SrcBOne;
          aluOp   = AluAdd;
          irWrite = memReady;
          pcWrite = memReady;
        end
        StDecode: begin
          aluSrcB = SrcBBrOff;
          aluOp   = AluAdd;
        end
        StExecR: aluSrcA = 1'b1;
        StWbR: begin
          regDst   = 1'b1;
          regWrite = 1'b1;
        end
        StExecI: begin
          aluSrcA = 1'b1;
          aluSrcB = SrcBImm;
          case (opCode)
            OpOri:   aluOp = AluOr;
            OpAndi:  aluOp = AluAnd;
            OpSlti:  aluOp = AluSlt;
            default: aluOp = AluAdd;
          endcase
        end
        StWbI: regWrite = 1'b1;
        StMemAddr: begin
          aluSrcA = 1'b1;
          aluSrcB = SrcBImm;
          aluOp   = AluAdd;
        end
        StMemRd: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        StMemWr: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
        end
        StWbMem: begin
          memToReg = 1'b1;
          regWrite = 1'b1;
        end
        StBranch: begin
          aluSrcA = 1'b1;
          aluOp   = AluSub;
          pcSrc   = PcSrcAluOut;
          pcWrite = zero;
        end
        StJump: begin
          pcSrc   = PcSrcJump;
          pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted     = (r_state == StHalt);
  assign memErr     = r_mem_err;
  assign illegalOp  = r_illegal;
  assign instrCount = r_instr_cnt;

endmodule
